// File: rtl/imm_extend_pipe.sv
// Pipelined MIPS immediate generator (sign/zero/upper/branch) with a 2-entry skid buffer.
// Latency 1 cycle; in_ready = !skid_valid, so there is no combinational path from out_ready.
module imm_extend_pipe #(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 32,
  parameter int BR_SHIFT = 2,
  parameter int TAG_W    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  localparam int UP_SHIFT = OUT_W - IN_W;
  localparam logic [OUT_W-1:0] LOW_MASK = OUT_W'({IN_W{1'b1}});

  logic [OUT_W-1:0] zero_ext, sign_ext, ext_res;
  logic             in_xfer, out_xfer;
  logic             or_valid, sk_valid;
  logic [OUT_W-1:0] or_data, sk_data;
  logic [TAG_W-1:0] or_tag, sk_tag;

  // Mask-based sign extension stays legal when OUT_W == IN_W (no zero-width replication).
  always_comb begin
    zero_ext = OUT_W'(in_imm);
    sign_ext = zero_ext | (in_imm[IN_W-1] ? ~LOW_MASK : '0);
    ext_res  = sign_ext;
    case (in_mode)
      2'b00:   ext_res = sign_ext;
      2'b01:   ext_res = zero_ext;
      2'b10:   ext_res = zero_ext << UP_SHIFT;
      default: ext_res = sign_ext << BR_SHIFT;
    endcase
  end

  assign in_ready  = !sk_valid;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = or_valid && out_ready;
  assign out_valid = or_valid;
  assign out_data  = or_data;
  assign out_tag   = or_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      or_valid <= 1'b0;
      or_data  <= '0;
      or_tag   <= '0;
      sk_valid <= 1'b0;
      sk_data  <= '0;
      sk_tag   <= '0;
    end else if (out_xfer) begin
      if (sk_valid) begin
        // in_ready was low, so no input can collide with the skid drain.
        or_data  <= sk_data;
        or_tag   <= sk_tag;
        sk_valid <= 1'b0;
      end else if (in_xfer) begin
        or_data <= ext_res;
        or_tag  <= in_tag;
      end else begin
        or_valid <= 1'b0;
      end
    end else if (in_xfer) begin
      if (!or_valid) begin
        or_valid <= 1'b1;
        or_data  <= ext_res;
        or_tag   <= in_tag;
      end else begin
        sk_valid <= 1'b1;
        sk_data  <= ext_res;
        sk_tag   <= in_tag;
      end
    end
  end

endmodule
